// File: rtl/clock_pkg.sv
// Shared types and BCD helpers for the multi-alarm clock core.
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } alarm_state_t;

    localparam logic [7:0] BCD_MAX_MIN  = 8'h59;
    localparam logic [7:0] BCD_MAX_HOUR = 8'h23;

    typedef struct packed {
        logic [7:0] hour;
        logic [7:0] minute;
    } hm_t;

    function automatic logic bcd_valid(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter with synchronous load, wrapping at MOD-1.
module bcd_mod_counter #(
    parameter int unsigned MOD = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] value,
    output logic       carry_c
);

    localparam int unsigned MAX_BIN = MOD - 1;
    localparam logic [7:0]  MAX_BCD = 8'(((MAX_BIN / 10) << 4) | (MAX_BIN % 10));

    logic [7:0] next_val;

    // BCD increment: wrap at the modulus, otherwise ripple the units digit
    always_comb begin
        next_val = value;
        if (value == MAX_BCD) begin
            next_val = 8'h00;
        end else if (value[3:0] == 4'd9) begin
            next_val = {value[7:4] + 4'd1, 4'd0};
        end else begin
            next_val = {value[7:4], value[3:0] + 4'd1};
        end
    end

    assign carry_c = inc && (value == MAX_BCD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= 8'h00;
        end else if (load) begin
            value <= load_val;
        end else if (inc) begin
            value <= next_val;
        end
    end

endmodule

// File: rtl/multi_alarm_clock_core.sv
// Timekeeping core: 1 Hz prescaler, BCD hh:mm:ss, N alarm channels and a
// ring/snooze state machine.
module multi_alarm_clock_core
    import clock_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned N_ALARMS   = 4,
    parameter int unsigned SNOOZE_MIN = 5,
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SELW       = $clog2(N_ALARMS + 1)
) (
    input  logic                clk_50m,
    input  logic                cr,
    input  logic                en,
    input  logic                wr_en,
    input  logic [SELW-1:0]     wr_sel,
    input  logic [7:0]          wr_hour,
    input  logic [7:0]          wr_min,
    input  logic [N_ALARMS-1:0] alarm_mask,
    input  logic                snooze,
    input  logic                stop,
    output logic [7:0]          hour,
    output logic [7:0]          minute,
    output logic [7:0]          second,
    output logic                tick_1hz,
    output logic                ringing,
    output logic [SELW-1:0]     ring_id,
    output logic                wr_err
);

    localparam int unsigned PRE_W     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned SNZ_TICKS = SNOOZE_MIN * 60;
    localparam int unsigned SNZ_W     = $clog2(SNZ_TICKS + 1);
    localparam int unsigned RING_W    = 8;

    logic [PRE_W-1:0]  pre_cnt;
    logic              wrap_c;
    logic              tick_fire_c;
    logic              wr_valid_c;
    logic              clk_wr_c;
    logic              sec_carry_c;
    logic              min_carry_c;
    logic              hour_carry_unused;
    hm_t               alarm_q [N_ALARMS];

    logic              match_c;
    logic [SELW-1:0]   match_id_c;
    logic              mask_held_c;

    alarm_state_t      state_q, state_d;
    logic              ringing_d;
    logic [SELW-1:0]   ring_id_d;
    logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
    logic [SNZ_W-1:0]  snooze_cnt_q, snooze_cnt_d;

    // Write validation covers digits, time ranges and the target index
    assign wr_valid_c = bcd_valid(wr_hour) && bcd_valid(wr_min)
                     && (wr_hour <= BCD_MAX_HOUR) && (wr_min <= BCD_MAX_MIN)
                     && (wr_sel <= SELW'(N_ALARMS));
    assign clk_wr_c    = wr_en && wr_valid_c && (wr_sel == '0);
    assign wrap_c      = en && (pre_cnt == PRE_W'(CLK_HZ - 1));
    assign tick_fire_c = wrap_c && !clk_wr_c;

    always_ff @(posedge clk_50m or posedge cr) begin
        if (cr) begin
            pre_cnt  <= '0;
            tick_1hz <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            tick_1hz <= tick_fire_c;
            wr_err   <= wr_en && !wr_valid_c;
            if (clk_wr_c || wrap_c) begin
                pre_cnt <= '0;
            end else if (en) begin
                pre_cnt <= pre_cnt + PRE_W'(1);
            end
        end
    end

    bcd_mod_counter #(.MOD(60)) u_second (
        .clk      (clk_50m),
        .rst      (cr),
        .inc      (tick_fire_c),
        .load     (clk_wr_c),
        .load_val (8'h00),
        .value    (second),
        .carry_c  (sec_carry_c)
    );

    bcd_mod_counter #(.MOD(60)) u_minute (
        .clk      (clk_50m),
        .rst      (cr),
        .inc      (sec_carry_c),
        .load     (clk_wr_c),
        .load_val (wr_min),
        .value    (minute),
        .carry_c  (min_carry_c)
    );

    bcd_mod_counter #(.MOD(24)) u_hour (
        .clk      (clk_50m),
        .rst      (cr),
        .inc      (min_carry_c),
        .load     (clk_wr_c),
        .load_val (wr_hour),
        .value    (hour),
        .carry_c  (hour_carry_unused)
    );

    always_ff @(posedge clk_50m or posedge cr) begin
        if (cr) begin
            for (int k = 0; k < int'(N_ALARMS); k++) begin
                alarm_q[k] <= '0;
            end
        end else if (wr_en && wr_valid_c) begin
            for (int k = 0; k < int'(N_ALARMS); k++) begin
                if (wr_sel == SELW'(k + 1)) begin
                    alarm_q[k] <= '{hour: wr_hour, minute: wr_min};
                end
            end
        end
    end

    // Match on the tick that lands on second 00; lowest channel wins
    always_comb begin
        match_c    = 1'b0;
        match_id_c = '0;
        for (int k = int'(N_ALARMS) - 1; k >= 0; k--) begin
            if (alarm_mask[k] && (alarm_q[k].hour == hour)
                && (alarm_q[k].minute == minute)) begin
                match_c    = 1'b1;
                match_id_c = SELW'(k + 1);
            end
        end
        if (!tick_1hz || (second != 8'h00)) begin
            match_c = 1'b0;
        end
    end

    always_comb begin
        mask_held_c = 1'b0;
        for (int k = 0; k < int'(N_ALARMS); k++) begin
            if (ring_id == SELW'(k + 1)) begin
                mask_held_c = alarm_mask[k];
            end
        end
    end

    always_ff @(posedge clk_50m or posedge cr) begin
        if (cr) begin
            state_q      <= IDLE;
            ringing      <= 1'b0;
            ring_id      <= '0;
            ring_cnt_q   <= '0;
            snooze_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            ringing      <= ringing_d;
            ring_id      <= ring_id_d;
            ring_cnt_q   <= ring_cnt_d;
            snooze_cnt_q <= snooze_cnt_d;
        end
    end

    // Stop beats mask loss beats snooze beats timeout
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (match_c) state_d = RING;
            end
            RING: begin
                if (stop || !mask_held_c) begin
                    state_d = IDLE;
                end else if (snooze) begin
                    state_d = SNOOZE;
                end else if (tick_1hz && (ring_cnt_q == RING_W'(RING_SEC - 1))) begin
                    state_d = IDLE;
                end
            end
            SNOOZE: begin
                if (stop || !mask_held_c) begin
                    state_d = IDLE;
                end else if (tick_1hz && (snooze_cnt_q == SNZ_W'(1))) begin
                    state_d = RING;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ringing_d    = 1'b0;
        ring_id_d    = ring_id;
        ring_cnt_d   = ring_cnt_q;
        snooze_cnt_d = snooze_cnt_q;
        unique case (state_d)
            IDLE: begin
                ring_id_d = '0;
            end
            RING: begin
                ringing_d = 1'b1;
                if (state_q == IDLE) ring_id_d = match_id_c;
                if (state_q != RING) begin
                    ring_cnt_d = '0;
                end else if (tick_1hz) begin
                    ring_cnt_d = ring_cnt_q + RING_W'(1);
                end
            end
            SNOOZE: begin
                if (state_q == RING) begin
                    snooze_cnt_d = SNZ_W'(SNZ_TICKS);
                end else if (tick_1hz) begin
                    snooze_cnt_d = snooze_cnt_q - SNZ_W'(1);
                end
            end
            default: ring_id_d = '0;
        endcase
    end

endmodule
